io_arbiter: RTL and testbench

IO_ARBITER -- requirements
Module: io_arbiter

---
 rtl/io_arbiter_pkg.sv | 18 +
 rtl/io_arbiter_pick.sv | 13 +
 rtl/io_arbiter.sv | 141 ++++++++++++++
 tb/tb_io_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_arbiter_pkg.sv
// Shared types for the two-requester IO arbiter: FSM state encoding and latched command.
package io_arbiter_pkg;

    localparam int unsigned IO_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic             we;
        logic [IO_DW-1:0] addr;
        logic [IO_DW-1:0] wd;
    } io_cmd_t;

endpackage

// File: rtl/io_arbiter_pick.sv
// Combinational 2-way winner select; on a tie the requester not granted last wins.
module io_arb_pick (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic valid,
    output logic win
);

    assign valid = req0 | req1;
    assign win   = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/io_arbiter.sv
// Two-requester IO bus arbiter: IDLE -> ISSUE -> RESP, one transaction per three cycles.
// Define IO_ARB_RR_EN for round-robin tie breaking; default is fixed priority to requester 0.
module io_arbiter
    import io_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic [IO_DW-1:0] addr0,
    input  logic [IO_DW-1:0] addr1,
    input  logic [IO_DW-1:0] wd0,
    input  logic [IO_DW-1:0] wd1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rvalid0,
    output logic             rvalid1,
    output logic [IO_DW-1:0] rdata0,
    output logic [IO_DW-1:0] rdata1,
    output logic             io_we,
    output logic [IO_DW-1:0] io_addr,
    output logic [IO_DW-1:0] io_wd,
    input  logic [IO_DW-1:0] io_rd
);

    arb_state_e       state_q;
    arb_state_e       state_d;
    io_cmd_t          cmd_q;
    logic             win_q;
    logic             pick_valid;
    logic             pick_win;
    logic             last_gnt;
    logic             take;
    logic [IO_DW-1:0] rdata0_q;
    logic [IO_DW-1:0] rdata1_q;

    assign take = (state_q == ST_IDLE) && pick_valid;

    io_arb_pick u_pick (
        .req0  (req0),
        .req1  (req1),
        .last  (last_gnt),
        .valid (pick_valid),
        .win   (pick_win)
    );

`ifdef IO_ARB_RR_EN
    logic last_q;

    // Reset to "requester 1 granted last" so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_q <= 1'b1;
        end else if (take) begin
            last_q <= pick_win;
        end
    end

    assign last_gnt = last_q;
`else
    assign last_gnt = 1'b1;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (pick_valid) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Command is captured once at the grant decision; later input changes are ignored.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cmd_q <= '0;
            win_q <= 1'b0;
        end else if (take) begin
            win_q <= pick_win;
            cmd_q <= pick_win ? io_cmd_t'{we1, addr1, wd1} : io_cmd_t'{we0, addr0, wd0};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else if (state_q == ST_RESP) begin
            if (win_q) begin
                rdata1_q <= io_rd;
            end else begin
                rdata0_q <= io_rd;
            end
        end
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        rvalid0 = 1'b0;
        rvalid1 = 1'b0;
        io_we   = 1'b0;
        io_addr = '0;
        io_wd   = '0;
        rdata0  = rdata0_q;
        rdata1  = rdata1_q;
        case (state_q)
            ST_ISSUE: begin
                gnt0    = ~win_q;
                gnt1    = win_q;
                io_we   = cmd_q.we;
                io_addr = cmd_q.addr;
                io_wd   = cmd_q.wd;
            end
            ST_RESP: begin
                rvalid0 = ~win_q;
                rvalid1 = win_q;
                if (win_q) begin
                    rdata1 = io_rd;
                end else begin
                    rdata0 = io_rd;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_io_arbiter.sv
// Self-checking bench for io_arbiter: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a transaction-schedule model.
module tb_io_arbiter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wd0 = '0, wd1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1, io_we;
    logic [31:0] rdata0, rdata1, io_addr, io_wd, io_rd;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    io_arbiter dut (
        .clk     (clk),
        .rstn    (rstn),
        .req0    (req0),
        .req1    (req1),
        .we0     (we0),
        .we1     (we1),
        .addr0   (addr0),
        .addr1   (addr1),
        .wd0     (wd0),
        .wd1     (wd1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .rvalid0 (rvalid0),
        .rvalid1 (rvalid1),
        .rdata0  (rdata0),
        .rdata1  (rdata1),
        .io_we   (io_we),
        .io_addr (io_addr),
        .io_wd   (io_wd),
        .io_rd   (io_rd)
    );

    function automatic logic [31:0] init_val(input int i);
        if (i == 0) return 32'hA5A5_0001;
        return 32'h1000_0000 | 32'(i);
    endfunction

    // IO register block: four registers, registered read data, write on io_we.
    logic [31:0] regs [4];
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 4; i++) regs[i] <= init_val(i);
            io_rd <= '0;
        end else begin
            io_rd <= regs[io_addr[3:2]];
            if (io_we) regs[io_addr[3:2]] <= io_wd;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic to_sample();
        @(negedge clk);
    endtask

    // Model: a decision in an idle cycle k schedules grant at k+1, response at k+2, next decision k+3.
    int          cyc = 0;
    int          m_free = 0, m_gnt = -1, m_resp = -1;
    logic        m_win = 1'b0, m_last = 1'b1, m_we = 1'b0;
    logic [31:0] m_addr = '0, m_wd = '0, m_exp = '0, m_hold0 = '0, m_hold1 = '0;
    logic [31:0] m_mem [4];

    always @(negedge clk) begin
        logic [4:0]  e_flags;
        logic [31:0] e_addr, e_wd, e_rd0, e_rd1;
        if (!rstn) begin
            m_free  = 0;
            m_gnt   = -1;
            m_resp  = -1;
            m_last  = 1'b1;
            m_hold0 = '0;
            m_hold1 = '0;
            for (int i = 0; i < 4; i++) m_mem[i] = init_val(i);
        end
        e_flags = '0;
        e_addr  = '0;
        e_wd    = '0;
        e_rd0   = m_hold0;
        e_rd1   = m_hold1;
        if (cyc == m_gnt) begin
            e_flags[4] = !m_win;
            e_flags[3] = m_win;
            e_flags[0] = m_we;
            e_addr     = m_addr;
            e_wd       = m_wd;
        end
        if (cyc == m_resp) begin
            e_flags[2] = !m_win;
            e_flags[1] = m_win;
            if (m_win) e_rd1 = m_exp;
            else       e_rd0 = m_exp;
        end
        check("model gnt0,gnt1,rvalid0,rvalid1,io_we", {27'd0, gnt0, gnt1, rvalid0, rvalid1, io_we},
              {27'd0, e_flags});
        check("model io_addr", io_addr, e_addr);
        check("model io_wd", io_wd, e_wd);
        check("model rdata0", rdata0, e_rd0);
        check("model rdata1", rdata1, e_rd1);
        if (cyc == m_resp) begin
            if (m_win) m_hold1 = m_exp;
            else       m_hold0 = m_exp;
            if (m_we) m_mem[m_addr[3:2]] = m_wd;
        end
        if (rstn && cyc >= m_free && (req0 || req1)) begin
            if (req0 && req1) begin
`ifdef IO_ARB_RR_EN
                m_win = !m_last;
`else
                m_win = 1'b0;
`endif
            end else begin
                m_win = req1;
            end
            m_last = m_win;
            m_we   = m_win ? we1 : we0;
            m_addr = m_win ? addr1 : addr0;
            m_wd   = m_win ? wd1 : wd0;
            m_exp  = m_mem[m_addr[3:2]];
            m_gnt  = cyc + 1;
            m_resp = cyc + 2;
            m_free = cyc + 3;
        end
        cyc++;
    end

    logic saw0 = 1'b0, saw1 = 1'b0;
    always @(negedge clk) begin
        saw0 <= gnt0;
        saw1 <= gnt1;
    end

    initial begin
        int code;
        int exp_code;

        to_sample();
        to_sample();
        check("reset ctl", {27'd0, gnt0, gnt1, rvalid0, rvalid1, io_we}, 32'd0);
        check("reset io_addr", io_addr, 32'd0);
        check("reset rdata0", rdata0, 32'd0);

        // Read of address 0 by requester 0.
        to_drive(); rstn = 1'b1; req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0;
        to_sample(); check("rd idle gnt0", gnt0, 32'd0);
        to_drive(); to_sample();
        check("rd gnt0", gnt0, 32'd1);
        check("rd io_addr", io_addr, 32'h0);
        check("rd io_we", io_we, 32'd0);
        to_drive(); req0 = 1'b0; to_sample();
        check("rd rvalid0", rvalid0, 32'd1);
        check("rd rdata0", rdata0, 32'hA5A5_0001);

        // Write of 0xDEADBEEF to address 4 by requester 1.
        to_drive(); req1 = 1'b1; we1 = 1'b1; addr1 = 32'h4; wd1 = 32'hDEAD_BEEF; to_sample();
        to_drive(); to_sample();
        check("wr gnt1", gnt1, 32'd1);
        check("wr io_we", io_we, 32'd1);
        check("wr io_wd", io_wd, 32'hDEAD_BEEF);
        check("wr io_addr", io_addr, 32'h4);
        to_drive(); req1 = 1'b0; we1 = 1'b0; to_sample();
        check("wr rvalid1", rvalid1, 32'd1);
        check("wr io_we off", io_we, 32'd0);
        check("wr rdata0 held", rdata0, 32'hA5A5_0001);
        to_drive(); to_sample();
        check("wr io_we after", io_we, 32'd0);
        check("wr rvalid1 once", rvalid1, 32'd0);

        // Address change during ISSUE must not affect the transaction.
        to_drive(); req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0; to_sample();
        to_drive(); addr0 = 32'h4; to_sample();
        check("latch io_addr", io_addr, 32'h0);
        to_drive(); req0 = 1'b0; to_sample();
        check("latch rvalid0", rvalid0, 32'd1);
        check("latch rdata0", rdata0, 32'hA5A5_0001);

        // Fresh reset, then four back-to-back ties.
        to_drive(); rstn = 1'b0; to_sample();
        check("reset clears rdata0", rdata0, 32'd0);
        to_drive(); rstn = 1'b1; req0 = 1'b1; req1 = 1'b1; addr0 = 32'h0; addr1 = 32'h4;
        we0 = 1'b0; we1 = 1'b0;
        for (int t = 0; t < 4; t++) begin
            to_sample();
            to_drive(); to_sample();
            code = gnt0 ? 0 : (gnt1 ? 1 : 3);
`ifdef IO_ARB_RR_EN
            exp_code = t % 2;
`else
            exp_code = 0;
`endif
            check("tie grant order", code, exp_code);
            to_drive(); to_sample();
            to_drive();
        end
        req0 = 1'b0; req1 = 1'b0;

        // Reset during RESP of a requester-1 read aborts it.
        to_drive(); req1 = 1'b1; we1 = 1'b0; addr1 = 32'h4; to_sample();
        to_drive(); to_sample();
        check("abort gnt1", gnt1, 32'd1);
        to_drive(); req1 = 1'b0; rstn = 1'b0; to_sample();
        check("abort ctl", {27'd0, gnt0, gnt1, rvalid0, rvalid1, io_we}, 32'd0);
        check("abort rdata1", rdata1, 32'd0);
        to_drive(); rstn = 1'b1; req0 = 1'b1; req1 = 1'b1; to_sample();
        check("abort no rvalid1", rvalid1, 32'd0);
        to_drive(); to_sample();
        check("post-reset tie gnt0", gnt0, 32'd1);
        check("post-reset tie gnt1", gnt1, 32'd0);
        to_drive(); req0 = 1'b0; to_sample();
        to_drive(); to_sample();
        to_drive(); to_sample();
        check("loser served gnt1", gnt1, 32'd1);
        to_drive(); req1 = 1'b0; to_sample();
        to_drive();

        // Continuous requester-0 stream.
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h8;
        for (int j = 0; j < 12; j++) begin
            to_sample();
            check("stream gnt0", gnt0, 32'((j % 3) == 1));
            check("stream rvalid0", rvalid0, 32'((j % 3) == 2));
            check("stream no req1 activity", {31'd0, gnt1 | rvalid1}, 32'd0);
            to_drive();
        end
        req0 = 1'b0;

        // Randomized traffic with occasional resets; the model process checks every cycle.
        for (int n = 0; n < 3000; n++) begin
            to_drive();
            rstn = ($urandom_range(0, 199) != 0);
            if (saw0) begin
                req0 = 1'b0;
            end else if (!req0 && $urandom_range(0, 2) == 0) begin
                req0  = 1'b1;
                we0   = 1'($urandom_range(0, 1));
                addr0 = $urandom;
                wd0   = $urandom;
            end
            if ($urandom_range(0, 3) == 0) begin
                addr0 = $urandom;
                wd0   = $urandom;
            end
            if (saw1) begin
                req1 = 1'b0;
            end else if (!req1 && $urandom_range(0, 2) == 0) begin
                req1  = 1'b1;
                we1   = 1'($urandom_range(0, 1));
                addr1 = $urandom;
                wd1   = $urandom;
            end
            if ($urandom_range(0, 3) == 0) begin
                addr1 = $urandom;
                wd1   = $urandom;
            end
        end
        to_drive(); rstn = 1'b1; req0 = 1'b0; req1 = 1'b0;
        repeat (4) to_sample();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
